ah_lru_rsp_router: RTL
======================

Name: ah_lru_rsp_router

Overview:
- Return-path companion to the 7-way LRU arbiter.
- Records, in order, which requester won each accepted grant; routes the shared resource's in-order responses back to that requester with valid/ready handshake.
- Drives the arbiter's gnt_busy input when its tag FIFO is full, so no grant is issued that cannot be tracked.

Parameters:
N, 7, number of requesters (matches arbiter width)
DEPTH, 8, max outstanding accepted grants (tag FIFO entries, power of 2)
DW, 32, response data width

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
gnt  in  N  one-hot grant from arbiter
gnt_accept  in  1  shared resource accepts the granted transaction this cycle
gnt_busy  out  N  all bits = FIFO full; feeds arbiter gnt_busy
rsp_vld  in  1  response valid from shared resource
rsp_rdy  out  1  response accepted by router
rsp_data  in  DW  response payload
rsp_vld_out  out  N  per-requester response valid (at most one bit set)
rsp_rdy_in  in  N  per-requester ready
rsp_data_out  out  DW  payload broadcast to all requesters (= rsp_data)
outstanding  out  $clog2(DEPTH+1)  current FIFO occupancy
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (async, rstn=0): wr_ptr=rd_ptr=0, count=0, err=0 -> gnt_busy=0, rsp_vld_out=0, rsp_rdy=0, outstanding=0. Reset mid-transaction discards all tags; responses in flight are dropped (rsp_rdy=0 while empty).
- Push: gnt_accept & |gnt & (count<DEPTH) -> write bin index of gnt to FIFO[wr_ptr], wr_ptr++ (wraps mod DEPTH). Fullness is evaluated on registered count before any same-cycle pop.
- Non-one-hot gnt with accept: push index of lowest set bit.
- gnt_accept with gnt=0: no push.
- gnt_accept while full: no push, tag lost (error case).
- gnt_busy = {N{count==DEPTH}}, combinational from registered count.
- Head = FIFO[rd_ptr].
- rsp_vld_out[i] = rsp_vld & (count!=0) & (head==i).
- rsp_rdy = (count!=0) & rsp_rdy_in[head].
- Pop: rsp_vld & rsp_rdy -> rd_ptr++ (wraps mod DEPTH).
- Response to an empty FIFO: rsp_rdy=0, nothing routed, stalls until a tag exists.
- Push and pop in the same cycle: count unchanged, both pointers advance. Legal at count=0 only if the push precedes the pop; a tag written in cycle T is routable from T+1 (one-cycle minimum grant-to-response latency, no bypass).
- Responses are strictly in grant-accept order; no reordering.
- outstanding = count; range 0..DEPTH, never wraps.

Optional Feature:
- Macro AH_LRU_RSP_ROUTER_CHK_EN.
- Defined: err sets and holds until reset on any of:
  - gnt_accept with non-one-hot nonzero gnt
  - gnt_accept while full (overflow)
  - rsp_vld while count==0 for 2+ consecutive cycles (underflow)
- Not defined: err tied 0; no checker logic synthesized.

Decomposition:
- Shared package ah_arb_pkg:
  - AH_ARB_N default (7)
  - idx width function clog2
  - err cause enum {ERR_NONE, ERR_ONEHOT, ERR_OVF, ERR_UNF}, used internally by the checker
- One natural sub-module ah_onehot2bin (N -> $clog2(N), lowest-set-bit priority); reusable by the arbiter.

Test Plan:
- Single grant: gnt=7'b0000100, accept in cycle 1, rsp_vld in cycle 3 -> rsp_vld_out=7'b0000100 in cycle 3, pop, outstanding 1->0.
- Order: accept grants to requesters 6,0,3 back-to-back, then 3 responses -> rsp_vld_out 7'b1000000, 7'b0000001, 7'b0001000 in order.
- Full: 8 accepts without responses -> outstanding=8, gnt_busy=7'h7F; 9th accept not pushed; with CHK_EN err=1.
- Backpressure: head requester 2 with rsp_rdy_in[2]=0 for 3 cycles -> rsp_rdy=0, rsp_vld_out[2]=1, no pop; release -> pop in same cycle.
- Simultaneous push/pop at count=4 -> outstanding stays 4, pointers wrap correctly past index 7 over 10 iterations.
- Reset mid-run: count=5, rstn low -> outstanding=0, gnt_busy=0, rsp_vld_out=0 immediately (async), err cleared.

Source files
------------

// File: rtl/ah_arb_pkg.sv
// Shared definitions for the LRU arbiter family: requester count, index-width
// helper and the protocol-error cause encoding used by the response router checker.
package ah_arb_pkg;

  localparam int AH_ARB_N = 7;

  // Smallest r with 2**r >= value; usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_ONEHOT = 2'd1,
    ERR_OVF    = 2'd2,
    ERR_UNF    = 2'd3
  } err_cause_t;

endpackage

// File: rtl/ah_lru_rsp_router_if.sv
// Grant-side and response-side signal bundle between the arbiter/shared resource,
// the response router (slave) and the requesters.
interface ah_lru_rsp_router_if #(
  parameter int N     = ah_arb_pkg::AH_ARB_N,
  parameter int DEPTH = 8,
  parameter int DW    = 32
);
  localparam int CW = ah_arb_pkg::clog2(DEPTH + 1);

  logic [N-1:0]  gnt;
  logic          gnt_accept;
  logic [N-1:0]  gnt_busy;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_data;
  logic [N-1:0]  rsp_vld_out;
  logic [N-1:0]  rsp_rdy_in;
  logic [DW-1:0] rsp_data_out;
  logic [CW-1:0] outstanding;
  logic          err;

  modport slave (
    input  gnt, gnt_accept, rsp_vld, rsp_data, rsp_rdy_in,
    output gnt_busy, rsp_rdy, rsp_vld_out, rsp_data_out, outstanding, err
  );

  modport master (
    output gnt, gnt_accept, rsp_vld, rsp_data, rsp_rdy_in,
    input  gnt_busy, rsp_rdy, rsp_vld_out, rsp_data_out, outstanding, err
  );

endinterface

// File: rtl/ah_onehot2bin.sv
// One-hot to binary index encoder; when several bits are set the lowest one wins.
module ah_onehot2bin
  import ah_arb_pkg::*;
#(
  parameter int N  = AH_ARB_N,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  onehot,
  output logic [IW-1:0] bin
);

  // Scan from the top so the last (lowest) set bit overwrites any higher one.
  always_comb begin
    bin = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (onehot[i]) bin = IW'(i);
    end
  end

endmodule

// File: rtl/ah_lru_rsp_router.sv
// In-order response router for the LRU arbiter: a tag FIFO of granted requesters
// steers responses back. Define AH_LRU_RSP_ROUTER_CHK_EN to build the sticky err checker.
module ah_lru_rsp_router
  import ah_arb_pkg::*;
#(
  parameter int N     = AH_ARB_N,
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input logic                clk,
  input logic                rstn,
  ah_lru_rsp_router_if.slave bus
);

  localparam int IW = clog2(N);
  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] tag_mem_q [DEPTH];
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  ah_onehot2bin #(.N(N), .IW(IW)) u_gnt_enc (
    .onehot (bus.gnt),
    .bin    (gnt_idx)
  );

  // Fullness comes from the registered count, so a same-cycle pop never frees a slot early.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.gnt_accept & (|bus.gnt) & ~full;
  assign head  = tag_mem_q[rd_ptr_q];
  assign pop   = bus.rsp_vld & bus.rsp_rdy;

  assign bus.rsp_rdy      = ~empty & bus.rsp_rdy_in[head];
  assign bus.gnt_busy     = {N{full}};
  assign bus.rsp_data_out = bus.rsp_data;
  assign bus.outstanding  = count_q;

  for (genvar gi = 0; gi < N; gi++) begin : g_route
    assign bus.rsp_vld_out[gi] = bus.rsp_vld & ~empty & (head == IW'(gi));
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) tag_mem_q[wr_ptr_q] <= gnt_idx;
  end

`ifdef AH_LRU_RSP_ROUTER_CHK_EN
  err_cause_t err_cause_q, err_cause_d;
  logic       unf_seen_q, unf_seen_d;
  logic       multi_hot;

  assign multi_hot = |(bus.gnt & (bus.gnt - N'(1)));

  // First cause wins and is held until reset.
  always_comb begin
    err_cause_d = err_cause_q;
    unf_seen_d  = bus.rsp_vld & empty;
    if (err_cause_q == ERR_NONE) begin
      if (bus.gnt_accept & multi_hot)
        err_cause_d = ERR_ONEHOT;
      else if (bus.gnt_accept & (|bus.gnt) & full)
        err_cause_d = ERR_OVF;
      else if (unf_seen_q & bus.rsp_vld & empty)
        err_cause_d = ERR_UNF;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cause_q <= ERR_NONE;
      unf_seen_q  <= 1'b0;
    end else begin
      err_cause_q <= err_cause_d;
      unf_seen_q  <= unf_seen_d;
    end
  end

  assign bus.err = (err_cause_q != ERR_NONE);
`else
  assign bus.err = 1'b0;
`endif

endmodule
